// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding.
package timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSE   = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler for the countdown timer: counts 0..TICK_DIV-1 while enabled and
// flags the wrap cycle; holds its value while disabled.
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer with pause, auto-reload and saturating bonus-time add.
//   state     | meaning
//   S_IDLE    | Time held at INIT, waiting for start
//   S_RUN     | counting down, one step per prescaler wrap
//   S_PAUSE   | pause held high; count and prescaler frozen
//   S_EXPIRED | one-shot reached 0; only start or rst leaves
module countdown_timer #(
    parameter int TICK_DIV = 50000000,
    parameter int W        = 7,
    parameter int INIT     = 100,
    parameter int WARN     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pause,
    input  logic         reload_mode,
    input  logic         add_en,
    input  logic [W-1:0] add_val,
    output logic [W-1:0] Time,
    output logic         live,
    output logic         expired,
    output logic         warn,
    output logic         tick
);

    import timer_pkg::*;

    localparam logic [W-1:0] INIT_V = W'(INIT);
    localparam logic [W:0]   MAX_V  = {1'b0, {W{1'b1}}};
    localparam logic [W:0]   WARN_V = (W+1)'(WARN);
    localparam logic [W:0]   ONE_V  = (W+1)'(1);

    state_t       state_q, state_d;
    logic [W-1:0] time_q, time_d;
    logic [W:0]   sum;
    logic         expired_d;
    logic         presc_en;
    logic         presc_wrap;
    logic         active;

    assign active   = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign presc_en = active && !start && !pause;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (start),
        .tick (presc_wrap)
    );

    always_comb begin
        state_d   = state_q;
        time_d    = time_q;
        expired_d = 1'b0;
        sum       = '0;
        if (start) begin
            state_d = S_RUN;
            time_d  = INIT_V;
        end else if (active) begin
            // Time sits at 0 in RUN only for the cycle after an auto-reload expiry
            sum = (time_q == '0) ? {1'b0, INIT_V} : {1'b0, time_q};
            if (presc_wrap) sum = sum - ONE_V;
            if (add_en)     sum = sum + {1'b0, add_val};
            time_d  = (sum > MAX_V) ? {W{1'b1}} : sum[W-1:0];
            state_d = pause ? S_PAUSE : S_RUN;
            if (presc_wrap && (time_d == '0)) begin
                expired_d = 1'b1;
                if (!reload_mode) state_d = S_EXPIRED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            time_q  <= INIT_V;
            live    <= 1'b1;
            expired <= 1'b0;
            tick    <= 1'b0;
            warn    <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            live    <= (state_d != S_EXPIRED);
            expired <= expired_d;
            tick    <= presc_wrap;
            warn    <= ((state_d == S_RUN) || (state_d == S_PAUSE)) &&
                       (time_d != '0) && ({1'b0, time_d} <= WARN_V);
        end
    end

    assign Time = time_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random
// stimulus, all compared against an integer reference model.
module tb_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam int W        = 7;
    localparam int INIT     = 5;
    localparam int WARN     = 2;
    localparam int TMAX     = 127;

    logic         clk = 1'b0;
    logic         rst, start, pause, reload_mode, add_en;
    logic [W-1:0] add_val;
    logic [W-1:0] Time;
    logic         live, expired, warn, tick;

    countdown_timer #(
        .TICK_DIV (TICK_DIV),
        .W        (W),
        .INIT     (INIT),
        .WARN     (WARN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pause       (pause),
        .reload_mode (reload_mode),
        .add_en      (add_en),
        .add_val     (add_val),
        .Time        (Time),
        .live        (live),
        .expired     (expired),
        .warn        (warn),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: mode 0 = idle, 1 = counting (run or paused), 2 = expired
    int m_mode = 0;
    int m_time = INIT;
    int m_pre  = 0;
    bit m_due  = 1'b0;
    bit m_exp  = 1'b0;
    bit m_tick = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int t;
        m_exp  = 1'b0;
        m_tick = 1'b0;
        if (rst) begin
            m_mode = 0; m_time = INIT; m_pre = 0; m_due = 1'b0;
        end else if (start) begin
            m_mode = 1; m_time = INIT; m_pre = 0; m_due = 1'b0;
        end else if (m_mode == 1) begin
            t = m_due ? INIT : m_time;
            m_due = 1'b0;
            if (!pause) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre  = 0;
                    m_tick = 1'b1;
                    t      = t - 1;
                end else begin
                    m_pre = m_pre + 1;
                end
            end
            if (add_en) t = t + int'(add_val);
            if (t > TMAX) t = TMAX;
            if (m_tick && t == 0) begin
                m_exp = 1'b1;
                if (reload_mode) m_due = 1'b1;
                else             m_mode = 2;
            end
            m_time = t;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("time",    int'(Time),    m_time);
        chk("live",    int'(live),    (m_mode != 2) ? 1 : 0);
        chk("expired", int'(expired), int'(m_exp));
        chk("tick",    int'(tick),    int'(m_tick));
        chk("warn",    int'(warn),    (m_mode == 1 && m_time > 0 && m_time <= WARN) ? 1 : 0);
    endtask

    task automatic restart();
        rst = 1'b1; step(); rst = 1'b0;
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        int g;
        rst = 1'b1; start = 1'b0; pause = 1'b0; reload_mode = 1'b0;
        add_en = 1'b0; add_val = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_time_const", int'(Time), 5);
        chk("rst_live_const", int'(live), 1);

        // one-shot run to expiry
        start = 1'b1; step(); start = 1'b0;
        repeat (20) step();
        chk("oneshot_end_time", int'(Time), 0);
        chk("oneshot_end_live", int'(live), 0);
        repeat (3) step();

        // auto-reload
        reload_mode = 1'b1;
        restart();
        repeat (24) step();
        chk("reload_live", int'(live), 1);
        reload_mode = 1'b0;

        // pause after two prescaler counts
        restart();
        step(); step();
        pause = 1'b1;
        repeat (10) step();
        chk("pause_hold_time", int'(Time), 5);
        pause = 1'b0;
        step();
        chk("pause_no_tick_yet", int'(tick), 0);
        step();
        chk("pause_resume_tick", int'(tick), 1);
        chk("pause_resume_time", int'(Time), 4);
        repeat (3) step();

        // saturating add at Time=3
        restart();
        g = 0;
        while (m_time != 3 && g < 100) begin step(); g++; end
        chk("wait_time3", (g < 100) ? 1 : 0, 1);
        add_en = 1'b1; add_val = 7'd126; step(); add_en = 1'b0; add_val = '0;
        chk("sat_time", int'(Time), 127);

        // add coincident with final tick
        restart();
        g = 0;
        while (!(m_time == 1 && m_pre == TICK_DIV - 1) && g < 100) begin step(); g++; end
        chk("wait_time1", (g < 100) ? 1 : 0, 1);
        add_en = 1'b1; add_val = 7'd3; step(); add_en = 1'b0; add_val = '0;
        chk("coinc_time", int'(Time), 3);
        chk("coinc_expired", int'(expired), 0);
        chk("coinc_tick", int'(tick), 1);

        // reset mid-count, then restart from expired
        restart();
        g = 0;
        while (m_time != 2 && g < 100) begin step(); g++; end
        chk("wait_time2", (g < 100) ? 1 : 0, 1);
        step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_run_time", int'(Time), 5);
        chk("rst_run_tick", int'(tick), 0);
        chk("rst_run_expired", int'(expired), 0);
        start = 1'b1; step(); start = 1'b0;
        g = 0;
        while (m_mode != 2 && g < 100) begin step(); g++; end
        chk("wait_expired", (g < 100) ? 1 : 0, 1);
        step();
        start = 1'b1; step(); start = 1'b0;
        chk("restart_time", int'(Time), 5);
        chk("restart_live", int'(live), 1);

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) == 0)  pause = ~pause;
            if ($urandom_range(0, 99) == 0) reload_mode = ~reload_mode;
            add_en  = ($urandom_range(0, 14) == 0);
            add_val = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 127))
                                                  : W'($urandom_range(0, 3));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL expose parameter TICK_DIV, default 50000000, clk cycles per count step (min 2).
REQ-002 SHALL expose parameter W, default 7, width of the time value.
REQ-003 SHALL expose parameter INIT, default 100, value loaded on start (INIT <= 2^W-1, INIT >= 1).
REQ-004 SHALL expose parameter WARN, default 10, low-time warning threshold.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  load INIT and begin counting.
REQ-008 SHALL have port pause  input  1  level; hold count while high.
REQ-009 SHALL have port reload_mode  input  1  1 = auto-reload at expiry, 0 = one-shot.
REQ-010 SHALL have port add_en  input  1  one-cycle strobe to add bonus time.
REQ-011 SHALL have port add_val  input  W  bonus amount, sampled when add_en=1.
REQ-012 SHALL have port Time  output  W  remaining count.
REQ-013 SHALL have port live  output  1  high while not expired.
REQ-014 SHALL have port expired  output  1  one-cycle pulse on reaching 0.
REQ-015 SHALL have port warn  output  1  high when running/paused and 0 < Time <= WARN.
REQ-016 SHALL have port tick  output  1  one-cycle pulse per count step.

Function
REQ-017 SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-018 IDLE: Time=INIT, live=1, no counting; start -> RUN.
REQ-019 RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps to 0, tick=1 that cycle, Time decrements on same edge.
REQ-020 RUN with pause=1 -> PAUSE; prescaler and Time frozen (prescaler not cleared); pause=0 -> RUN, prescaler resumes from held value.
REQ-021 Tick with Time=1: Time becomes 0, expired=1 that cycle; one-shot -> EXPIRED; reload_mode=1 -> Time loads INIT on the next cycle, state stays RUN, live stays 1.
REQ-022 EXPIRED: Time=0, live=0, prescaler held at 0, tick=0; only start or rst leaves.
REQ-023 start in any state: Time=INIT, prescaler=0, state=RUN on next edge; start has priority over pause, add_en and tick in the same cycle.
REQ-024 add_en in RUN or PAUSE: Time = min(Time + add_val, 2^W-1), computed at W+1 bits; ignored in IDLE and EXPIRED.
REQ-025 add_en coincident with tick: result = saturate(Time - 1 + add_val); no expiry if result > 0.
REQ-026 add_val = 0 with add_en SHALL leave Time unchanged.
REQ-027 Time SHALL never underflow below 0 nor wrap above 2^W-1.
REQ-028 expired, tick SHALL be registered single-cycle pulses; warn, live registered levels.

Reset
REQ-029 rst=1 at a clock edge: state=IDLE, Time=INIT, prescaler=0, live=1, expired=0, tick=0, warn=0.
REQ-030 rst SHALL take priority over start and all other inputs, including mid-count and during PAUSE.
REQ-031 First cycle after rst release, outputs SHALL equal reset values until start.

Structure
REQ-032 Shared package timer_pkg SHALL hold the state enum and the state-encoding width constant.
REQ-033 Prescaler SHALL be sub-module tick_gen (params TICK_DIV; ports clk, rst, en, clr, tick), width $clog2(TICK_DIV).
REQ-034 Top SHALL contain the FSM, Time register, saturating add and output registers only.

Verification (bench with TICK_DIV=4, W=7, INIT=5, WARN=2)
REQ-035 rst, start, run 20 cycles -> Time steps 5,4,3,2,1,0 every 4 cycles; expired pulses once with Time->0; live=0 after; warn high at Time 2,1.
REQ-036 reload_mode=1, start, run 24 cycles -> Time 5..0 then back to 5 one cycle after expiry pulse; live stays 1.
REQ-037 pause after 2 prescaler counts for 10 cycles, release -> next tick occurs exactly 2 cycles after release; Time unchanged during pause.
REQ-038 Time=3, add_en add_val=126 -> Time=127 (saturated); add_en coincident with tick at Time=1, add_val=3 -> Time=3, no expired.
REQ-039 rst asserted in RUN at Time=2 -> next cycle Time=5, state IDLE, no tick/expired; start in EXPIRED -> Time=5, RUN, live=1.
